// File: rtl/pio_out_pkg.sv
// Shared register map and reset constants for the blinking output PIO.
package pio_out_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_SET      = 3'd1;
    localparam logic [2:0] ADDR_CLR      = 3'd2;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd3;
    localparam logic [2:0] ADDR_PERIOD   = 3'd4;
    localparam logic [2:0] ADDR_PRESCALE = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    // Timing registers come out of reset at their slowest setting.
    localparam logic [31:0] PERIOD_RESET   = 32'hFFFF_FFFF;
    localparam logic [31:0] PRESCALE_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/blink_timebase.sv
// Prescaler plus half-period counter producing the blink phase square wave.
module blink_timebase #(
    parameter int PRESCALE_W = 16,
    parameter int PERIOD_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PERIOD_W-1:0]   period,
    output logic                  tick,
    output logic                  phase
);

    logic [PRESCALE_W-1:0] prescale_cnt_reg;
    logic [PERIOD_W-1:0]   period_cnt_reg;
    logic                  phase_reg;

    assign tick  = (prescale_cnt_reg == prescale);
    assign phase = phase_reg;

    // A restart realigns the waveform so a new rate starts from a clean phase 0.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            prescale_cnt_reg <= '0;
            period_cnt_reg   <= '0;
            phase_reg        <= 1'b0;
        end else if (tick) begin
            prescale_cnt_reg <= '0;
            if (period_cnt_reg == period) begin
                period_cnt_reg <= '0;
                phase_reg      <= ~phase_reg;
            end else begin
                period_cnt_reg <= period_cnt_reg + 1'b1;
            end
        end else begin
            prescale_cnt_reg <= prescale_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/pio_out_blink.sv
// Avalon-MM output PIO with atomic set/clear and per-bit hardware blink.
module pio_out_blink #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PRESCALE_W  = 16,
    parameter int               PERIOD_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    import pio_out_pkg::*;

    logic [WIDTH-1:0]      data_reg;
    logic [WIDTH-1:0]      blink_en_reg;
    logic [PERIOD_W-1:0]   period_reg;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic                  wr_en;
    logic                  restart;
    logic                  tick;
    logic                  phase;
    logic [WIDTH-1:0]      wr_bits;
    logic                  unused_bits;

    assign wr_en   = chipselect && !write_n;
    assign wr_bits = writedata[WIDTH-1:0];
    assign restart = wr_en && ((address == ADDR_PERIOD) || (address == ADDR_PRESCALE));

    // Upper writedata bits and the tick strobe are intentionally not consumed here.
    assign unused_bits = ^{writedata, tick};

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg     <= RESET_VALUE;
            blink_en_reg <= '0;
            period_reg   <= PERIOD_RESET[PERIOD_W-1:0];
            prescale_reg <= PRESCALE_RESET[PRESCALE_W-1:0];
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data_reg     <= wr_bits;
                ADDR_SET:      data_reg     <= data_reg | wr_bits;
                ADDR_CLR:      data_reg     <= data_reg & ~wr_bits;
                ADDR_BLINK_EN: blink_en_reg <= wr_bits;
                ADDR_PERIOD:   period_reg   <= writedata[PERIOD_W-1:0];
                ADDR_PRESCALE: prescale_reg <= writedata[PRESCALE_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLR: readdata = 32'(data_reg);
            ADDR_BLINK_EN:                 readdata = 32'(blink_en_reg);
            ADDR_PERIOD:                   readdata = 32'(period_reg);
            ADDR_PRESCALE:                 readdata = 32'(prescale_reg);
            ADDR_STATUS:                   readdata = {31'd0, phase};
            default:                       readdata = '0;
        endcase
    end

    blink_timebase #(
        .PRESCALE_W (PRESCALE_W),
        .PERIOD_W   (PERIOD_W)
    ) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .prescale (prescale_reg),
        .period   (period_reg),
        .tick     (tick),
        .phase    (phase)
    );

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
            assign out_port[gi] = data_reg[gi] ^ (blink_en_reg[gi] & phase);
        end
    endgenerate

endmodule

// File: tb/tb_pio_out_blink.sv
// Directed bench for pio_out_blink: register access, set/clear, blink timing, reset.
module tb_pio_out_blink;

    localparam int WIDTH = 10;

    logic             clk;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int n;

    pio_out_blink #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (10'h155),
        .PRESCALE_W  (16),
        .PERIOD_W    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write spans exactly one rising edge; returns 1 ns after it.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("WR addr=%0d data=%08h -> out_port=%03h", a, d, out_port);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
        $display("RD addr=%0d data=%08h", a, d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total_cnt++;
        if (out_port !== 10'h155) $display("FAIL reset_out: got %03h expected 155", out_port);
        else pass_cnt++;
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 32'h155) $display("FAIL reset_data: got %08h expected 00000155", rd);
        else pass_cnt++;
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL reset_blink_en: got %08h expected 00000000", rd);
        else pass_cnt++;
        bus_read(3'd4, rd);
        total_cnt++;
        if (rd !== 32'hFFFF) $display("FAIL reset_period: got %08h expected 0000ffff", rd);
        else pass_cnt++;
        bus_read(3'd6, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL reset_status: got %08h expected 00000000", rd);
        else pass_cnt++;
    endtask

    task automatic test_data_set_clr();
        logic [31:0] rd;
        logic [2:0]  addrs [3] = '{3'd0, 3'd1, 3'd2};
        logic [31:0] wdat  [3] = '{32'h0F0, 32'h003, 32'h030};
        logic [9:0]  exp_v [3] = '{10'h0F0, 10'h0F3, 10'h0C3};
        logic [9:0]  prev;
        prev = 10'h155;
        for (int i = 0; i < 3; i++) begin
            address    = addrs[i];
            writedata  = wdat[i];
            chipselect = 1'b1;
            write_n    = 1'b0;
            #1;
            total_cnt++;
            if (out_port !== prev) $display("FAIL pre_edge_%0d: got %03h expected %03h", i, out_port, prev);
            else pass_cnt++;
            @(posedge clk);
            #1;
            chipselect = 1'b0;
            write_n    = 1'b1;
            total_cnt++;
            if (out_port !== exp_v[i]) $display("FAIL post_edge_%0d: got %03h expected %03h", i, out_port, exp_v[i]);
            else pass_cnt++;
            bus_read(addrs[i], rd);
            total_cnt++;
            if (rd !== 32'(exp_v[i])) $display("FAIL read_%0d: got %08h expected %08h", i, rd, 32'(exp_v[i]));
            else pass_cnt++;
            prev = exp_v[i];
        end
    endtask

    task automatic test_blink_slow();
        logic [31:0] rd;
        logic        ph;
        bus_write(3'd5, 32'd1);
        bus_write(3'd4, 32'd2);
        n = 0;
        bus_write(3'd3, 32'h001);
        n++;
        bus_write(3'd0, 32'h000);
        n++;
        for (int k = 0; k < 24; k++) begin
            ph = ((n / 6) % 2) == 1;
            total_cnt++;
            if (out_port !== {9'd0, ph}) $display("FAIL blink_out n=%0d: got %03h expected %03h", n, out_port, {9'd0, ph});
            else pass_cnt++;
            bus_read(3'd6, rd);
            total_cnt++;
            if (rd !== {31'd0, ph}) $display("FAIL blink_status n=%0d: got %08h expected %08h", n, rd, {31'd0, ph});
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_restart();
        logic ph;
        while (n < 32) step();
        total_cnt++;
        if (out_port !== 10'h001) $display("FAIL pre_restart: got %03h expected 001", out_port);
        else pass_cnt++;
        bus_write(3'd5, 32'd1);
        n = 0;
        for (int k = 0; k < 13; k++) begin
            ph = ((n / 6) % 2) == 1;
            total_cnt++;
            if (out_port !== {9'd0, ph}) $display("FAIL restart_out n=%0d: got %03h expected %03h", n, out_port, {9'd0, ph});
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_v;
        bus_write(3'd5, 32'd0);
        bus_write(3'd4, 32'd0);
        n = 0;
        bus_write(3'd3, 32'h3FF);
        n++;
        bus_write(3'd0, 32'h2AA);
        n++;
        for (int k = 0; k < 8; k++) begin
            exp_v = (n % 2 == 1) ? 10'h155 : 10'h2AA;
            total_cnt++;
            if (out_port !== exp_v) $display("FAIL fast_out n=%0d: got %03h expected %03h", n, out_port, exp_v);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_reset_midblink();
        logic [31:0] rd;
        reset      = 1'b1;
        address    = 3'd0;
        writedata  = 32'h3FF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        total_cnt++;
        if (out_port !== 10'h155) $display("FAIL midreset_out: got %03h expected 155", out_port);
        else pass_cnt++;
        bus_read(3'd6, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL midreset_status: got %08h expected 00000000", rd);
        else pass_cnt++;
        bus_read(3'd5, rd);
        total_cnt++;
        if (rd !== 32'hFFFF) $display("FAIL midreset_prescale: got %08h expected 0000ffff", rd);
        else pass_cnt++;
        repeat (3) step();
        total_cnt++;
        if (out_port !== 10'h155) $display("FAIL midreset_hold: got %03h expected 155", out_port);
        else pass_cnt++;
        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_read(3'd7, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL rsvd_read: got %08h expected 00000000", rd);
        else pass_cnt++;
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 32'h155) $display("FAIL rsvd_nowrite: got %08h expected 00000155", rd);
        else pass_cnt++;
        bus_write(3'd0, 32'hFFFF_FC00);
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL upper_bits: got %08h expected 00000000", rd);
        else pass_cnt++;
        bus_write(3'd1, 32'hFFFF_FC01);
        total_cnt++;
        if (out_port !== 10'h001) $display("FAIL upper_bits_set: got %03h expected 001", out_port);
        else pass_cnt++;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        n          = 0;
        test_reset();
        test_data_set_clr();
        test_blink_slow();
        test_restart();
        test_back_to_back();
        test_reset_midblink();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
